// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition counter bank:
// fill-type encodings and the default counter widths.
package adc_acq_pkg;

    typedef enum logic [1:0] {
        FILL_READOUT = 2'b00,
        FILL_T1      = 2'b01,
        FILL_T2      = 2'b10,
        FILL_T3      = 2'b11
    } fill_type_e;

    localparam int DEF_BURST_W = 23;
    localparam int DEF_WFM_W   = 12;
    localparam int DEF_GAP_W   = 22;
    localparam int DEF_FILL_W  = 24;

endpackage

// File: rtl/adc_acq_down_cntr.sv
// Loadable down-counter that saturates at zero and reports a zero flag.
// A load on the same cycle as a decrement takes priority and the decrement is lost.
module adc_acq_down_cntr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] load_val,
    input  logic         init,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Count register: load wins over decrement, and the decrement stops at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (init) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adc_acq_cntrs.sv
// Counter bank feeding the ADC acquisition state machine: per-fill size latch,
// burst/waveform/gap down-counters, fill and waveform numbering.
// Optional sticky error flag built only when ADC_ACQ_CNTR_ERR_EN is defined.
module adc_acq_cntrs
    import adc_acq_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int WFM_W   = DEF_WFM_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int FILL_W  = DEF_FILL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         fill_type,
    input  logic               fill_type_mux_en,
    input  logic [BURST_W-1:0] burst_count1,
    input  logic [BURST_W-1:0] burst_count2,
    input  logic [BURST_W-1:0] burst_count3,
    input  logic [WFM_W-1:0]   wfm_count1,
    input  logic [WFM_W-1:0]   wfm_count2,
    input  logic [WFM_W-1:0]   wfm_count3,
    input  logic [GAP_W-1:0]   waveform_gap,
    input  logic               burst_cntr_init,
    input  logic               burst_cntr_en,
    input  logic               waveform_cntr_init,
    input  logic               waveform_cntr_en,
    input  logic               waveform_gap_cntr_init,
    input  logic               waveform_gap_cntr_en,
    input  logic               fill_cntr_en,
    output logic               burst_cntr_zero,
    output logic               last_waveform,
    output logic               waveform_gap_zero,
    output logic [1:0]         fill_type_latched,
    output logic [BURST_W-1:0] burst_size,
    output logic [WFM_W-1:0]   wfm_size,
    output logic [FILL_W-1:0]  fill_num,
    output logic [WFM_W-1:0]   wfm_num,
    output logic               cntr_err
);

    logic [BURST_W-1:0] sel_burst;
    logic [WFM_W-1:0]   sel_wfm;

    // Pick the size set for the requested fill type; readout fills reuse set 1,
    // and a zero size is forced to 1 so a fill always has at least one unit.
    always_comb begin
        sel_burst = burst_count1;
        sel_wfm   = wfm_count1;
        case (fill_type)
            FILL_T2: begin
                sel_burst = burst_count2;
                sel_wfm   = wfm_count2;
            end
            FILL_T3: begin
                sel_burst = burst_count3;
                sel_wfm   = wfm_count3;
            end
            default: begin
                sel_burst = burst_count1;
                sel_wfm   = wfm_count1;
            end
        endcase
        if (sel_burst == '0) begin
            sel_burst = BURST_W'(1);
        end
        if (sel_wfm == '0) begin
            sel_wfm = WFM_W'(1);
        end
    end

    // Size latch, captured once per fill before the counters are initialised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_type_latched <= 2'b00;
            burst_size        <= '0;
            wfm_size          <= '0;
        end else if (fill_type_mux_en) begin
            fill_type_latched <= fill_type;
            burst_size        <= sel_burst;
            wfm_size          <= sel_wfm;
        end
    end

    adc_acq_down_cntr #(
        .W (BURST_W)
    ) u_burst_cntr (
        .clk      (clk),
        .reset    (reset),
        .load_val (burst_size),
        .init     (burst_cntr_init),
        .en       (burst_cntr_en),
        .zero     (burst_cntr_zero)
    );

    adc_acq_down_cntr #(
        .W (WFM_W)
    ) u_wfm_cntr (
        .clk      (clk),
        .reset    (reset),
        .load_val (wfm_size),
        .init     (waveform_cntr_init),
        .en       (waveform_cntr_en),
        .zero     (last_waveform)
    );

    adc_acq_down_cntr #(
        .W (GAP_W)
    ) u_gap_cntr (
        .clk      (clk),
        .reset    (reset),
        .load_val (waveform_gap),
        .init     (waveform_gap_cntr_init),
        .en       (waveform_gap_cntr_en),
        .zero     (waveform_gap_zero)
    );

    // Waveform index within the fill: restarts on init, counts up (wrapping) on each waveform.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wfm_num <= '0;
        end else if (waveform_cntr_init) begin
            wfm_num <= '0;
        end else if (waveform_cntr_en) begin
            wfm_num <= wfm_num + WFM_W'(1);
        end
    end

    // Completed-fill number, free-running with natural wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_num <= '0;
        end else if (fill_cntr_en) begin
            fill_num <= fill_num + FILL_W'(1);
        end
    end

`ifdef ADC_ACQ_CNTR_ERR_EN
    logic err_event;
    logic err_q;

    // An error is a decrement request on an already-empty counter (a load on the
    // same cycle cancels the decrement, so it is not an error) or a fill-number wrap.
    always_comb begin
        err_event = 1'b0;
        if (burst_cntr_en && !burst_cntr_init && burst_cntr_zero) begin
            err_event = 1'b1;
        end
        if (waveform_cntr_en && !waveform_cntr_init && last_waveform) begin
            err_event = 1'b1;
        end
        if (waveform_gap_cntr_en && !waveform_gap_cntr_init && waveform_gap_zero) begin
            err_event = 1'b1;
        end
        if (fill_cntr_en && (fill_num == '1)) begin
            err_event = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end
    end

    assign cntr_err = err_q;
`else
    assign cntr_err = 1'b0;
`endif

endmodule
